// File: rtl/crack_pkg.sv
// Shared types for the ARC4 key-search scheduler.
//   state_t : scheduler phase (IDLE -> RUN -> DRAIN -> IDLE)
//   key_t   : candidate key at the default key width
package crack_pkg;

    localparam int KEY_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [KEY_W_DEFAULT-1:0] key_t;

endpackage

// File: rtl/crack_issue_arb.sv
// Lowest-index-first priority picker.
//   req   : N request bits
//   grant : one-hot grant of the lowest set request bit (zero when none)
//   valid : at least one request bit is set
// Purely combinational; the scheduler uses one copy to choose the engine to
// issue to and another to choose the winning ok result.
module crack_issue_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         valid
);

    // seen[i] is set when any request below index i is present.
    logic [N:0] seen;

    assign seen[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pick
            assign grant[gi]  = req[gi] & ~seen[gi];
            assign seen[gi+1] = seen[gi] | req[gi];
        end
    endgenerate

    assign valid = seen[N];

endmodule

// File: rtl/crack_sched.sv
// Multi-engine ARC4 key-search scheduler.
// Walks the inclusive (possibly wrapping) range [key_start, key_end], issuing
// one candidate per cycle to the lowest-index free engine. Stops issuing on
// the first successful trial or when the range is exhausted, waits for all
// in-flight trials to finish, then returns to IDLE with the result.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en, rdy             start handshake (accepted when rdy=1)
//   key_start, key_end  inclusive search range, sampled on accept
//   key, key_valid      winning key and found flag of the last search
//   keys_tried          trials issued in the current/last search (saturating)
//   trial_en            one-cycle issue pulse per engine
//   trial_key           packed per-engine keys, engine i at [i*KEY_W +: KEY_W]
//   trial_rdy           engine idle
//   trial_done          one-cycle completion pulse per engine
//   trial_ok            qualifies trial_done: the key decrypted successfully
module crack_sched
    import crack_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int KEY_W  = KEY_W_DEFAULT,
    parameter int CNT_W  = KEY_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    rdy,
    input  logic [KEY_W-1:0]        key_start,
    input  logic [KEY_W-1:0]        key_end,
    output logic [KEY_W-1:0]        key,
    output logic                    key_valid,
    output logic [CNT_W-1:0]        keys_tried,
    output logic [NCORES-1:0]       trial_en,
    output logic [NCORES*KEY_W-1:0] trial_key,
    input  logic [NCORES-1:0]       trial_rdy,
    input  logic [NCORES-1:0]       trial_done,
    input  logic [NCORES-1:0]       trial_ok
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [KEY_W-1:0] KEY_ONE   = {{(KEY_W-1){1'b0}}, 1'b1};
    // Largest count a full-width range can reach (2^KEY_W trials).
    localparam logic [CNT_W-1:0] TRIED_MAX = CNT_ONE << KEY_W;

    state_t              state_reg;
    state_t              state_next;

    logic [KEY_W-1:0]    next_key_reg;
    logic [KEY_W-1:0]    last_key_reg;
    logic [KEY_W-1:0]    key_reg;
    logic                key_valid_reg;
    logic                found_reg;
    logic                exhausted_reg;
    logic [CNT_W-1:0]    keys_tried_reg;
    logic [NCORES-1:0]   busy_reg;
    logic [NCORES-1:0]   trial_en_reg;
    logic [KEY_W-1:0]    trial_key_reg [NCORES];
    logic [KEY_W-1:0]    inflight_reg  [NCORES];

    logic                accept;
    logic                live;
    logic [NCORES-1:0]   eligible;
    logic [NCORES-1:0]   issue_grant;
    logic                issue_avail;
    logic                issue_fire;
    logic [NCORES-1:0]   issue_vec;
    logic [NCORES-1:0]   done_valid;
    logic [NCORES-1:0]   ok_req;
    logic [NCORES-1:0]   ok_grant;
    logic                ok_any;
    logic                win;
    logic [KEY_W-1:0]    win_key;
    logic                drain_done;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (found_reg || exhausted_reg) state_next = DRAIN;
            DRAIN:   if (busy_reg == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and phase qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        // rdy is held low while reset is asserted, whatever the state.
        rdy        = (state_reg == IDLE) && !rst;
        accept     = (state_reg == IDLE) && en;
        live       = (state_reg == RUN) || (state_reg == DRAIN);
        drain_done = (state_reg == DRAIN) && (busy_reg == '0);
    end

    // ------------------------------------------------------------------
    // Issue selection: an engine is eligible only if it reports ready and
    // we do not already have a trial outstanding on it (busy is sampled at
    // the start of the cycle, so a done this cycle does not free it yet).
    // ------------------------------------------------------------------
    assign eligible = trial_rdy & ~busy_reg;

    crack_issue_arb #(.N(NCORES)) u_issue_arb (
        .req   (eligible),
        .grant (issue_grant),
        .valid (issue_avail)
    );

    // ------------------------------------------------------------------
    // Completion: results from engines we are not tracking are dropped.
    // ------------------------------------------------------------------
    assign done_valid = live ? (trial_done & busy_reg) : '0;
    assign ok_req     = done_valid & trial_ok;

    crack_issue_arb #(.N(NCORES)) u_ok_arb (
        .req   (ok_req),
        .grant (ok_grant),
        .valid (ok_any)
    );

    assign win = ok_any && !found_reg;

    always_comb begin
        win_key = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (ok_grant[i]) begin
                win_key = win_key | inflight_reg[i];
            end
        end
    end

    // Suppress the issue in the cycle the winning result arrives so that no
    // new trial is started once the key is known.
    assign issue_fire = (state_reg == RUN) && !found_reg && !exhausted_reg &&
                        !win && issue_avail;
    assign issue_vec  = issue_fire ? issue_grant : '0;

    // ------------------------------------------------------------------
    // Datapath: range counter, per-engine tracking, result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            next_key_reg   <= '0;
            last_key_reg   <= '0;
            key_reg        <= '0;
            key_valid_reg  <= 1'b0;
            found_reg      <= 1'b0;
            exhausted_reg  <= 1'b0;
            keys_tried_reg <= '0;
            busy_reg       <= '0;
            trial_en_reg   <= '0;
            for (int i = 0; i < NCORES; i++) begin
                trial_key_reg[i] <= '0;
                inflight_reg[i]  <= '0;
            end
        end else begin
            trial_en_reg <= issue_vec;
            busy_reg     <= (busy_reg & ~done_valid) | issue_vec;

            if (accept) begin
                next_key_reg   <= key_start;
                last_key_reg   <= key_end;
                key_valid_reg  <= 1'b0;
                keys_tried_reg <= '0;
                exhausted_reg  <= 1'b0;
                found_reg      <= 1'b0;
            end

            if (issue_fire) begin
                if (keys_tried_reg != TRIED_MAX) begin
                    keys_tried_reg <= keys_tried_reg + CNT_ONE;
                end
                // Compare before incrementing so a wrapping range ends on
                // key_end rather than on a magnitude test.
                if (next_key_reg == last_key_reg) begin
                    exhausted_reg <= 1'b1;
                end else begin
                    next_key_reg <= next_key_reg + KEY_ONE;
                end
            end

            if (win) begin
                key_reg   <= win_key;
                found_reg <= 1'b1;
            end

            if (drain_done) begin
                key_valid_reg <= found_reg;
            end

            for (int i = 0; i < NCORES; i++) begin
                if (issue_vec[i]) begin
                    trial_key_reg[i] <= next_key_reg;
                    inflight_reg[i]  <= next_key_reg;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_pack
            assign trial_key[gi*KEY_W +: KEY_W] = trial_key_reg[gi];
        end
    endgenerate

    assign key        = key_reg;
    assign key_valid  = key_valid_reg;
    assign keys_tried = keys_tried_reg;
    assign trial_en   = trial_en_reg;

endmodule

// File: tb/tb_crack_sched.sv
// Directed bench for crack_sched with a behavioural four-engine model
// (fixed 6-cycle latency, ok when the key equals a chosen match key).
// Issued keys are checked in order against a queue filled when each search
// is started; search results are checked against a second queue when the
// scheduler returns to idle.
module tb_crack_sched;

    localparam int NC = 4;
    localparam int KW = 24;
    localparam int CW = KW + 1;

    typedef struct {
        logic [KW-1:0] key;
        logic          valid;
        int            tmin;
        int            tmax;
    } result_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              rdy;
    logic [KW-1:0]     key_start;
    logic [KW-1:0]     key_end;
    logic [KW-1:0]     key;
    logic              key_valid;
    logic [CW-1:0]     keys_tried;
    logic [NC-1:0]     trial_en;
    logic [NC*KW-1:0]  trial_key;
    logic [NC-1:0]     trial_rdy;
    logic [NC-1:0]     trial_done;
    logic [NC-1:0]     trial_ok;

    int vectors     = 0;
    int miscompares = 0;

    // engine model state
    logic [NC-1:0] eng_busy;
    logic [KW-1:0] eng_key [NC];
    int            eng_cnt [NC];
    logic [KW-1:0] match;
    bit            force_pair;

    logic [KW-1:0] exp_issue [$];
    result_t       exp_res   [$];
    int            n_issued;
    int            late_issues;
    int            ok_age;

    crack_sched #(.NCORES(NC), .KEY_W(KW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rdy        (rdy),
        .key_start  (key_start),
        .key_end    (key_end),
        .key        (key),
        .key_valid  (key_valid),
        .keys_tried (keys_tried),
        .trial_en   (trial_en),
        .trial_key  (trial_key),
        .trial_rdy  (trial_rdy),
        .trial_done (trial_done),
        .trial_ok   (trial_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_ok(input logic [KW-1:0] k);
        return (k == match) || (force_pair && (k == 24'h5 || k == 24'h7));
    endfunction

    function automatic int lat(input logic [KW-1:0] k);
        return (force_pair && k == 24'h5) ? 8 : 6;
    endfunction

    // One clock: sample DUT 1 time unit after the edge, advance the engine
    // model, check any issue against the expected-key queue.
    task automatic cycle();
        logic [KW-1:0] k;
        logic [63:0]   ek;
        @(posedge clk);
        #1;
        if (ok_age >= 0) ok_age++;
        trial_done = '0;
        trial_ok   = '0;
        for (int i = 0; i < NC; i++) begin
            if (eng_busy[i]) begin
                eng_cnt[i]--;
                if (eng_cnt[i] == 0) begin
                    trial_done[i] = 1'b1;
                    trial_ok[i]   = is_ok(eng_key[i]);
                    eng_busy[i]   = 1'b0;
                end
            end
        end
        if (trial_ok != '0 && ok_age < 0) ok_age = 0;
        if (trial_en !== '0) begin
            check("issue_onehot", 64'($countones(trial_en)), 64'd1);
            for (int i = 0; i < NC; i++) begin
                if (trial_en[i]) begin
                    k = trial_key[i*KW +: KW];
                    n_issued++;
                    if (ok_age >= 2) late_issues++;
                    ek = (exp_issue.size() > 0) ? 64'(exp_issue.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF;
                    check("issue_key", 64'(k), ek);
                    $display("issue engine %0d key %06h (trial %0d)", i, k, n_issued);
                    eng_busy[i] = 1'b1;
                    eng_key[i]  = k;
                    eng_cnt[i]  = lat(k);
                end
            end
        end
        trial_rdy = ~eng_busy;
    endtask

    task automatic start(input logic [KW-1:0] ks, input logic [KW-1:0] ke, input bit hold);
        logic [KW-1:0] k;
        exp_issue.delete();
        k = ks;
        for (int n = 0; n < 300; n++) begin
            exp_issue.push_back(k);
            if (k == ke) break;
            k = k + 24'd1;
        end
        n_issued    = 0;
        late_issues = 0;
        ok_age      = -1;
        key_start   = ks;
        key_end     = ke;
        en          = 1'b1;
        cycle();
        if (!hold) en = 1'b0;
        check("accept_rdy_drop", 64'(rdy), 64'd0);
        check("accept_clear_valid", 64'(key_valid), 64'd0);
        check("accept_tried_zero", 64'(keys_tried), 64'd0);
        check("accept_no_issue_yet", 64'(trial_en), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        result_t r;
        int      budget;
        budget = 3000;
        while (rdy !== 1'b1 && budget > 0) begin
            cycle();
            budget--;
        end
        check({tag, "_timeout"}, 64'(rdy), 64'd1);
        if (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            $display("%s done: key %06h valid %0b tried %0d", tag, key, key_valid, keys_tried);
            check({tag, "_valid"}, 64'(key_valid), 64'(r.valid));
            if (r.valid) check({tag, "_key"}, 64'(key), 64'(r.key));
            check({tag, "_tried_range"}, 64'(int'(keys_tried) >= r.tmin && int'(keys_tried) <= r.tmax), 64'd1);
            check({tag, "_tried_vs_issued"}, 64'(keys_tried), 64'(n_issued));
        end
    endtask

    initial begin
        int budget;
        rst        = 1'b1;
        en         = 1'b0;
        key_start  = '0;
        key_end    = '0;
        trial_done = '0;
        trial_ok   = '0;
        eng_busy   = '0;
        trial_rdy  = '1;
        match      = 24'hFFFFFF;
        force_pair = 1'b0;
        n_issued   = 0;
        ok_age     = -1;
        for (int i = 0; i < NC; i++) begin
            eng_key[i] = '0;
            eng_cnt[i] = 0;
        end

        // Power-up reset
        cycle();
        cycle();
        check("reset_rdy_low", 64'(rdy), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_rdy", 64'(rdy), 64'd1);
        check("reset_key", 64'(key), 64'd0);
        check("reset_key_valid", 64'(key_valid), 64'd0);
        check("reset_tried", 64'(keys_tried), 64'd0);
        check("reset_trial_en", 64'(trial_en), 64'd0);

        // 1. Reset mid-RUN with three engines busy; key 1 is in flight and
        //    would succeed, but its completion arrives after the reset.
        match = 24'h000001;
        start(24'h000000, 24'h0000FF, 1'b0);
        budget = 50;
        while ($countones(eng_busy) < 3 && budget > 0) begin
            cycle();
            budget--;
        end
        check("t1_three_busy", 64'($countones(eng_busy)), 64'd3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        exp_issue.delete();
        n_issued = 0;
        check("t1_rdy", 64'(rdy), 64'd1);
        check("t1_key_valid", 64'(key_valid), 64'd0);
        check("t1_tried", 64'(keys_tried), 64'd0);
        check("t1_trial_en", 64'(trial_en), 64'd0);
        check("t1_trial_key", 64'(trial_key), 64'd0);
        repeat (12) cycle();
        check("t1_stale_key_valid", 64'(key_valid), 64'd0);
        check("t1_stale_key", 64'(key), 64'd0);
        check("t1_no_issue", 64'(n_issued), 64'd0);
        check("t1_rdy_hold", 64'(rdy), 64'd1);

        // 2. Basic find
        match = 24'h000013;
        exp_res.push_back('{key: 24'h000013, valid: 1'b1, tmin: 'h14, tmax: 'h17});
        start(24'h000000, 24'h0000FF, 1'b0);
        wait_idle("t2");
        check("t2_no_late_issue", 64'(late_issues), 64'd0);

        // 3. Exhaustion, no match; previous result held until accept
        check("t3_key_held", 64'(key), 64'h13);
        check("t3_valid_held", 64'(key_valid), 64'd1);
        match = 24'hFFFFFF;
        exp_res.push_back('{key: 24'h0, valid: 1'b0, tmin: 16, tmax: 16});
        start(24'h000010, 24'h00001F, 1'b0);
        wait_idle("t3");
        check("t3_all_issued", 64'(exp_issue.size()), 64'd0);
        check("t3_issue_count", 64'(n_issued), 64'd16);

        // 4. Wrap-around
        match = 24'h000001;
        exp_res.push_back('{key: 24'h000001, valid: 1'b1, tmin: 18, tmax: 20});
        start(24'hFFFFF0, 24'h000003, 1'b0);
        wait_idle("t4");

        // 5. Engines 1 and 3 report ok in the same cycle (keys 5 and 7)
        match      = 24'hFFFFFF;
        force_pair = 1'b1;
        exp_res.push_back('{key: 24'h000005, valid: 1'b1, tmin: 8, tmax: 16});
        start(24'h000000, 24'h0000FF, 1'b0);
        wait_idle("t5");
        force_pair = 1'b0;

        // 6. Single-key range with en held high throughout
        match = 24'h0000AB;
        exp_res.push_back('{key: 24'h0000AB, valid: 1'b1, tmin: 1, tmax: 1});
        start(24'h0000AB, 24'h0000AB, 1'b1);
        wait_idle("t6a");
        check("t6a_one_trial", 64'(n_issued), 64'd1);
        exp_issue.delete();
        exp_issue.push_back(24'h0000AB);
        n_issued = 0;
        exp_res.push_back('{key: 24'h0000AB, valid: 1'b1, tmin: 1, tmax: 1});
        cycle();
        en = 1'b0;
        check("t6b_reaccept_rdy", 64'(rdy), 64'd0);
        check("t6b_reaccept_clear_valid", 64'(key_valid), 64'd0);
        wait_idle("t6b");
        check("t6b_one_trial", 64'(n_issued), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crack_sched.md
Name: crack_sched

Overview:
- Parametrised multi-engine ARC4 key-search scheduler; successor to the single-engine crack block.
- Walks an inclusive key range [key_start, key_end], which may wrap, and hands one candidate key at a time to NCORES trial engines (ARC4 init + decrypt + printable check, external).
- Stops at the first successful trial or when the range is exhausted, drains in-flight trials, then reports the result.
- Sits between the top-level task controller and the engine array.

Parameters:
- NCORES, 4, number of trial engines driven (1..16).
- KEY_W, 24, key width in bits.
- CNT_W, KEY_W+1, width of the trial counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  start request; accepted only when rdy=1
- rdy  output  1  scheduler idle, can accept en
- key_start  input  KEY_W  first key to try; sampled on accept
- key_end  input  KEY_W  last key to try, inclusive; sampled on accept
- key  output  KEY_W  winning key; valid when key_valid=1
- key_valid  output  1  a key was found in the last search
- keys_tried  output  CNT_W  number of trials issued in the current/last search
- trial_en  output  NCORES  one-cycle issue pulse per engine
- trial_key  output  NCORES*KEY_W  key for engine i at bits [i*KEY_W +: KEY_W]
- trial_rdy  input  NCORES  engine i idle, can accept trial_en
- trial_done  input  NCORES  one-cycle completion pulse from engine i
- trial_ok  input  NCORES  qualifies trial_done: key i decrypted to a valid message

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state:
  - state=IDLE; rdy=0 during reset, 1 from the first cycle after rst deasserts.
  - key=0, key_valid=0, keys_tried=0, trial_en=0, trial_key=0.
  - All per-engine busy flags cleared; in-flight engine results are ignored.
- States: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - rdy=1.
  - en=1 at an edge: latch key_start into next_key and key_end into last_key; clear key_valid, keys_tried and the exhausted/found flags; go to RUN.
  - rdy drops the next cycle.
  - key and key_valid hold the previous result until this accept.
- RUN, issue rules:
  - At most one issue per cycle.
  - Target = lowest-index engine with trial_rdy[i]=1 and busy[i]=0.
  - On issue: trial_en[i]=1 for exactly one cycle; trial_key[i]=next_key, held until the next issue to that engine; busy[i] set; inflight_key[i]=next_key; keys_tried+1.
  - If next_key==last_key, set exhausted. Otherwise next_key+1, modulo 2^KEY_W.
  - Wrap: key_end < key_start searches start..2^KEY_W-1, then 0..end.
  - key_start==key_end gives exactly one trial.
  - First trial_en is no earlier than the cycle after accept.
- Completion, evaluated every cycle in RUN or DRAIN:
  - trial_done[i] clears busy[i].
  - If trial_ok[i]=1 and found=0: key<=inflight_key[i], found=1.
  - Several ok in the same cycle: lowest index wins.
  - ok after found is ignored.
  - trial_done on a non-busy engine is ignored.
  - A done and a new issue to the same engine in the same cycle: issue requires busy=0 at the start of the cycle, so the engine is re-issued no earlier than the next cycle.
- RUN -> DRAIN when found=1 or exhausted=1; no further issues.
- DRAIN:
  - Wait until busy==0, then go to IDLE with key_valid=found.
  - An in-flight trial completing ok during DRAIN can still win, if found=0 at that point.
- en while not rdy is ignored.
- keys_tried saturates at 2^KEY_W; the full range needs CNT_W=KEY_W+1.

Decomposition:
- Package crack_pkg: state enum (IDLE, RUN, DRAIN), default KEY_W, key_t typedef.
- Sub-module crack_issue_arb: NCORES-wide lowest-index-first priority picker returning a one-hot grant and a valid bit; used for both issue and ok-win selection.
- Range counter, busy/inflight arrays and FSM stay in crack_sched.

Test Plan:
Bench uses a behavioural engine model with fixed latency 6 cycles and ok when key==MATCH; NCORES=4.
1. Reset mid-RUN: rst=1 for 1 cycle with 3 engines busy -> next cycle rdy=1, key_valid=0, keys_tried=0, trial_en=0; stale trial_done pulses ignored.
2. Basic find: key_start=0x000000, key_end=0x0000FF, MATCH=0x000013 -> key=0x000013, key_valid=1, rdy back to 1; keys_tried between 0x14 and 0x17; no trial_en after found.
3. Exhaustion, no match: key_start=0x000010, key_end=0x00001F -> keys_tried=16, key_valid=0; each key 0x10..0x1F issued exactly once.
4. Wrap-around: key_start=0xFFFFF0, key_end=0x000003, MATCH=0x000001 -> issue order 0xFFFFF0..0xFFFFFF, 0x000000, 0x000001...; key=0x000001, key_valid=1.
5. Simultaneous ok: engines 1 and 3 both pulse trial_done/trial_ok in the same cycle (model forces ok for keys 0x05 and 0x07) -> key=inflight key of engine 1, i.e. 0x05.
6. Single-key range with en held high after completion: key_start=key_end=0x0000AB -> exactly one trial_en; en while busy ignored; en accepted again once rdy=1, and the second search clears key_valid on accept.
